// File: rtl/mult8x8_seq_ctrl_pkg.sv
// Shared types, constants and helpers for the time-shared 8x8 multiplier controller.
// Quadrant q uses a-nibble q[1] and b-nibble q[0].
package mult8x8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] quad_idx_t;

    localparam int unsigned QUAD_SHIFT [4] = '{0, 4, 4, 8};

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_OR  = 1'b1;

    // Lowest-index set bit of the remaining-quadrant mask (0 when mask is empty).
    function automatic quad_idx_t lowest_quad(input logic [3:0] mask);
        quad_idx_t idx;
        idx = '0;
        for (int q = 3; q >= 0; q--) begin
            if (mask[q]) begin
                idx = quad_idx_t'(q);
            end
        end
        return idx;
    endfunction

    // Quadrants that will actually take a cycle, decided once at accept.
    function automatic logic [3:0] active_quads(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [3:0] qen,
        input logic       skip_zero
    );
        logic za_lo, za_hi, zb_lo, zb_hi;
        logic [3:0] zero;
        za_lo = (a[3:0] == 4'd0);
        za_hi = (a[7:4] == 4'd0);
        zb_lo = (b[3:0] == 4'd0);
        zb_hi = (b[7:4] == 4'd0);
        zero  = {za_hi | zb_hi, za_hi | zb_lo, za_lo | zb_hi, za_lo | zb_lo};
        return skip_zero ? (qen & ~zero) : qen;
    endfunction

endpackage

// File: rtl/mult8x8_seq_ctrl_if.sv
// Request/response handshake bundle for the sequential 8x8 multiplier.
// master = producer/consumer side, slave = multiplier side.
interface mult8x8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        mode;
    logic [3:0]  qen;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;
    logic        busy;

    modport master (
        output in_valid, a, b, mode, qen, out_ready,
        input  in_ready, out_valid, r, busy
    );

    modport slave (
        input  in_valid, a, b, mode, qen, out_ready,
        output in_ready, out_valid, r, busy
    );
endinterface

// File: rtl/mult8x8_seq_ctrl_mul4x4_core.sv
// Exact combinational 4x4 -> 8-bit multiplier shared by all quadrants.
module mul4x4_core (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    assign p = {4'b0000, x} * {4'b0000, y};
endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 multiplier: one 4x4 core walks the active nibble quadrants,
// combining partial products by exact add or approximate OR.
module mult8x8_seq_ctrl
    import mult8x8_seq_pkg::*;
#(
    parameter logic SKIP_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    mult8x8_seq_ctrl_if.slave   bus
);

    state_t      state_reg, state_next;
    logic [7:0]  a_reg, a_next;
    logic [7:0]  b_reg, b_next;
    logic        mode_reg, mode_next;
    logic [3:0]  rem_reg, rem_next;
    logic [15:0] acc_reg, acc_next;

    logic [3:0]  accept_mask;
    logic [3:0]  rem_cleared;
    quad_idx_t   cur;
    logic [3:0]  core_x, core_y;
    logic [7:0]  core_p;
    logic [15:0] term;

    assign accept_mask = active_quads(bus.a, bus.b, bus.qen, SKIP_ZERO);
    assign cur         = lowest_quad(rem_reg);
    assign rem_cleared = rem_reg & ~(4'b0001 << cur);

    assign core_x = cur[1] ? a_reg[7:4] : a_reg[3:0];
    assign core_y = cur[0] ? b_reg[7:4] : b_reg[3:0];

    mul4x4_core u_core (
        .x (core_x),
        .y (core_y),
        .p (core_p)
    );

    assign term = {8'h00, core_p} << QUAD_SHIFT[cur];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            mode_reg  <= MODE_ADD;
            rem_reg   <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            mode_reg  <= mode_next;
            rem_reg   <= rem_next;
            acc_reg   <= acc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        mode_next  = mode_reg;
        rem_next   = rem_reg;
        acc_next   = acc_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next     = bus.a;
                    b_next     = bus.b;
                    mode_next  = bus.mode;
                    rem_next   = accept_mask;
                    acc_next   = '0;
                    state_next = (accept_mask != 4'd0) ? CALC : DONE;
                end
            end
            CALC: begin
                acc_next   = (mode_reg == MODE_OR) ? (acc_reg | term) : (acc_reg + term);
                rem_next   = rem_cleared;
                if (rem_cleared == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg == CALC) || (state_reg == DONE);
    assign bus.r         = acc_reg;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Directed bench: identical stimulus to a SKIP_ZERO=1 and a SKIP_ZERO=0 instance.
module tb_mult8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        mode = 1'b0;
    logic [3:0]  qen = '0;
    logic        out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult8x8_seq_ctrl_if bus_s ();
    mult8x8_seq_ctrl_if bus_n ();

    assign bus_s.in_valid  = in_valid;
    assign bus_s.a         = a;
    assign bus_s.b         = b;
    assign bus_s.mode      = mode;
    assign bus_s.qen       = qen;
    assign bus_s.out_ready = out_ready;
    assign bus_n.in_valid  = in_valid;
    assign bus_n.a         = a;
    assign bus_n.b         = b;
    assign bus_n.mode      = mode;
    assign bus_n.qen       = qen;
    assign bus_n.out_ready = out_ready;

    mult8x8_seq_ctrl #(.SKIP_ZERO(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    mult8x8_seq_ctrl #(.SKIP_ZERO(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    // Drives one request, measures edges from accept to out_valid on both instances, then drains.
    task automatic do_txn(input logic [7:0] ta, input logic [7:0] tb, input logic tm, input logic [3:0] tq,
                          output int lat_s, output int lat_n, output logic [15:0] r_s, output logic [15:0] r_n);
        @(posedge clk); #1;
        in_valid = 1'b1; a = ta; b = tb; mode = tm; qen = tq;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = ~tb; mode = ~tm; qen = ~tq;
        lat_s = -1;
        lat_n = -1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (bus_s.out_valid && lat_s < 0) lat_s = k;
            if (bus_n.out_valid && lat_n < 0) lat_n = k;
        end
        r_s = bus_s.r;
        r_n = bus_n.r;
        $display("txn a=%02h b=%02h mode=%0d qen=%b : skip r=%04h lat=%0d | noskip r=%04h lat=%0d",
                 ta, tb, tm, tq, r_s, lat_s, r_n, lat_n);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus_s.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus_s.in_ready); end
        checks++; if (bus_s.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus_s.out_valid); end
        checks++; if (bus_s.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_s.busy); end
        checks++; if (bus_s.r !== 16'h0000) begin errors++; $display("FAIL reset_r got=%04h exp=0000", bus_s.r); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_exact_full();
        int ls, ln; logic [15:0] rs, rn;
        do_txn(8'hFF, 8'hFF, 1'b0, 4'b1111, ls, ln, rs, rn);
        checks++; if (rs !== 16'hFE01) begin errors++; $display("FAIL ff_ff_r got=%04h exp=FE01", rs); end
        checks++; if (ls !== 4) begin errors++; $display("FAIL ff_ff_lat got=%0d exp=4", ls); end
        checks++; if (rn !== 16'hFE01) begin errors++; $display("FAIL ff_ff_r_noskip got=%04h exp=FE01", rn); end
        do_txn(8'h12, 8'h34, 1'b0, 4'b1111, ls, ln, rs, rn);
        checks++; if (rs !== 16'h03A8) begin errors++; $display("FAIL 12_34_add_r got=%04h exp=03A8", rs); end
        checks++; if (ls !== 4) begin errors++; $display("FAIL 12_34_add_lat got=%0d exp=4", ls); end
    endtask

    task automatic test_or_mode();
        int ls, ln; logic [15:0] rs, rn;
        do_txn(8'h12, 8'h34, 1'b1, 4'b1111, ls, ln, rs, rn);
        checks++; if (rs !== 16'h0368) begin errors++; $display("FAIL 12_34_or_r got=%04h exp=0368", rs); end
        checks++; if (ls !== 4) begin errors++; $display("FAIL 12_34_or_lat got=%0d exp=4", ls); end
        checks++; if (rn !== 16'h0368) begin errors++; $display("FAIL 12_34_or_r_noskip got=%04h exp=0368", rn); end
    endtask

    task automatic test_skip_zero();
        int ls, ln; logic [15:0] rs, rn;
        do_txn(8'h05, 8'h07, 1'b0, 4'b1111, ls, ln, rs, rn);
        checks++; if (rs !== 16'h0023) begin errors++; $display("FAIL skip_r got=%04h exp=0023", rs); end
        checks++; if (ls !== 1) begin errors++; $display("FAIL skip_lat got=%0d exp=1", ls); end
        checks++; if (rn !== 16'h0023) begin errors++; $display("FAIL noskip_r got=%04h exp=0023", rn); end
        checks++; if (ln !== 4) begin errors++; $display("FAIL noskip_lat got=%0d exp=4", ln); end
    endtask

    task automatic test_qen_mask();
        int ls, ln; logic [15:0] rs, rn;
        do_txn(8'hFF, 8'hFF, 1'b0, 4'b0001, ls, ln, rs, rn);
        checks++; if (rs !== 16'h00E1) begin errors++; $display("FAIL qen0001_r got=%04h exp=00E1", rs); end
        checks++; if (ls !== 1) begin errors++; $display("FAIL qen0001_lat got=%0d exp=1", ls); end
        do_txn(8'hFF, 8'hFF, 1'b0, 4'b1000, ls, ln, rs, rn);
        checks++; if (rs !== 16'hE100) begin errors++; $display("FAIL qen1000_r got=%04h exp=E100", rs); end
        do_txn(8'hFF, 8'hFF, 1'b0, 4'b0000, ls, ln, rs, rn);
        checks++; if (rs !== 16'h0000) begin errors++; $display("FAIL qen0000_r got=%04h exp=0000", rs); end
        checks++; if (ls !== 0) begin errors++; $display("FAIL qen0000_lat got=%0d exp=0", ls); end
        checks++; if (ln !== 0) begin errors++; $display("FAIL qen0000_lat_noskip got=%0d exp=0", ln); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        in_valid = 1'b1; a = 8'h12; b = 8'h34; mode = 1'b0; qen = 4'b1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bus_s.out_valid !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", bus_s.out_valid); end
        in_valid = 1'b1; a = 8'h33; b = 8'h44;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus_s.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, bus_s.out_valid); end
            checks++; if (bus_s.r !== 16'h03A8) begin errors++; $display("FAIL bp_hold_r[%0d] got=%04h exp=03A8", i, bus_s.r); end
            checks++; if (bus_s.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d] got=%b exp=0", i, bus_s.in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (bus_s.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", bus_s.in_ready); end
        checks++; if (bus_s.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", bus_s.out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (bus_s.busy !== 1'b1) begin errors++; $display("FAIL bp_reaccept_busy got=%b exp=1", bus_s.busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_s.out_valid !== 1'b0) begin errors++; $display("FAIL bp_early_valid got=%b exp=0", bus_s.out_valid); end
        @(posedge clk); #1;
        checks++; if (bus_s.out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got=%b exp=1", bus_s.out_valid); end
        checks++; if (bus_s.r !== 16'h0D8C) begin errors++; $display("FAIL bp_second_r got=%04h exp=0D8C", bus_s.r); end
        $display("txn backpressure: first r=03A8 held, second a=33 b=44 r=%04h", bus_s.r);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int ls, ln; logic [15:0] rs, rn;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; mode = 1'b0; qen = 4'b1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus_s.r !== 16'h00E1) begin errors++; $display("FAIL midrst_partial_r got=%04h exp=00E1", bus_s.r); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus_s.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", bus_s.out_valid); end
        checks++; if (bus_s.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", bus_s.in_ready); end
        checks++; if (bus_s.r !== 16'h0000) begin errors++; $display("FAIL midrst_r got=%04h exp=0000", bus_s.r); end
        checks++; if (bus_n.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus_n.busy); end
        $display("txn reset asserted during second CALC cycle");
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_txn(8'h12, 8'h34, 1'b1, 4'b1111, ls, ln, rs, rn);
        checks++; if (rs !== 16'h0368) begin errors++; $display("FAIL midrst_after_r got=%04h exp=0368", rs); end
        checks++; if (ls !== 4) begin errors++; $display("FAIL midrst_after_lat got=%0d exp=4", ls); end
    endtask

    initial begin
        test_reset();
        test_exact_full();
        test_or_mode();
        test_skip_zero();
        test_qen_mask();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult8x8_seq_ctrl.md
# mult8x8_seq_ctrl

Sequential 8x8 multiplier controller that time-shares a single 4x4 multiplier core across the four nibble partial products of an 8x8 multiply. Partial products combine either exactly (add) or approximately (OR), selectable per transaction. Quadrants can be disabled or skipped for latency/accuracy trade-off. Sits between a valid/ready producer and consumer in the approximate-multiplier library as the area-reduced alternative to the four-core parallel 8x8 multipliers.

## Interface
- SKIP_ZERO, 1, when 1 a quadrant whose A-nibble or B-nibble is zero is skipped (no cycle spent)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- a  in  8  multiplicand, latched on accept
- b  in  8  multiplier, latched on accept
- mode  in  1  0 = exact add combine, 1 = OR combine; latched on accept
- qen  in  4  quadrant enable mask, bit q enables quadrant q; latched on accept
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer ready
- r  out  16  accumulator; meaningful only while out_valid
- busy  out  1  high in CALC or DONE

## Operation
- Quadrants: q0 = a[3:0]*b[3:0] shift 0; q1 = a[3:0]*b[7:4] shift 4; q2 = a[7:4]*b[3:0] shift 4; q3 = a[7:4]*b[7:4] shift 8.
- Active set = qen bits set, minus (if SKIP_ZERO) quadrants with a zero nibble operand. Computed once at accept; N = popcount(active set).
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid: latch a, b, mode, and active set; clear acc to 0. Go to CALC if N>0, else DONE.
  - CALC: each cycle process the lowest-index remaining active quadrant. Update acc = acc + (pp<<sh) in mode 0, or acc | (pp<<sh) in mode 1. Clear that quadrant's bit. After the last active quadrant, go to DONE.
  - DONE: out_valid=1; r stable. On out_ready go to IDLE.
- Mode 0 never overflows: max sum is 0xFE01 < 2^16. No saturation logic.
- in_valid outside IDLE is ignored and not queued. a/b/mode/qen may change freely after accept.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, r 0x0000, acc and latched operands 0.

## Timing
- Accept on the edge where in_valid && in_ready (edge t).
- out_valid rises after edge t+N, with N in 0..4. N=0 gives out_valid right after the accept edge.
- Full exact multiply with no skips: 4-cycle latency.
- Leaving DONE on edge u (out_ready high): in_ready is high after u. The next accept is at the earliest on edge u+1. Throughput is one result per N+2 cycles.
- out_ready high before DONE has no effect.
- rst_n low at any time, including mid-CALC or in DONE: immediately forces IDLE and the reset values. The in-flight result is discarded. Operation resumes on the first edge after rst_n deasserts.

## Structure
- Package mult8x8_seq_pkg holds:
  - state enum (IDLE, CALC, DONE)
  - 2-bit quadrant index type
  - shift constants {0,4,4,8}
  - mode encodings (MODE_ADD=0, MODE_OR=1)
- Sub-module mul4x4_core: purely combinational exact 4x4 -> 8-bit product, one instance. The controller muxes nibbles into it by quadrant index.
- Priority-encoder function (lowest remaining active quadrant) lives in the package.

## Test plan
- mode=0, qen=1111, a=0xFF, b=0xFF -> r=0xFE01, out_valid 4 cycles after accept.
- a=0x12, b=0x34, qen=1111: mode=0 -> r=0x03A8; mode=1 -> r=0x0368. Both with latency 4.
- SKIP_ZERO=1, qen=1111, a=0x05, b=0x07 -> only q0 active, r=0x0023, latency 1. With SKIP_ZERO=0: same r, latency 4.
- a=0xFF, b=0xFF, mode=0: qen=0001 -> r=0x00E1, latency 1. qen=0000 -> r=0x0000, out_valid right after the accept edge.
- Backpressure: hold out_ready low 3 cycles in DONE, driving in_valid=1 with new operands. Required: out_valid and r stable, in_ready 0, new request not accepted until 1 cycle after out_ready handshake.
- Assert rst_n low during the 2nd CALC cycle. Required: out_valid 0, in_ready 1, r 0 immediately. A new request afterwards produces the correct result.
